mult_sequencer: RTL and testbench

MULT_SEQUENCER -- requirements
Module: mult_sequencer

---
 rtl/mult_sequencer_if.sv | 26 ++
 rtl/mult_sequencer.sv | 135 +++++++++++++
 tb/tb_mult_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_sequencer_if.sv
// Bundle of the multiply request/result handshake and the shared-ALU bus.
// The sequencer takes the slave side; the requester and the ALU take the master side.
interface mult_sequencer_if;
   logic        start;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        busy;
   logic        done;
   logic [31:0] product;
   logic        alu_own;
   logic [3:0]  alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [4:0]  alu_shamt;
   logic [31:0] alu_result;

   modport master (
      output start, op_a, op_b, alu_result,
      input  busy, done, product, alu_own, alu_op, alu_a, alu_b, alu_shamt
   );

   modport slave (
      input  start, op_a, op_b, alu_result,
      output busy, done, product, alu_own, alu_op, alu_a, alu_b, alu_shamt
   );
endinterface

// File: rtl/mult_sequencer.sv
// Shift-and-add multiplier that borrows a shared ALU: one ADD and one SHIFT cycle per multiplier bit.
// Optional MULT_EARLY_EXIT_EN finishes as soon as no multiplier bits remain set.
module mult_sequencer #(
   parameter int N_BITS = 32
) (
   input  logic             clk,
   input  logic             reset,
   mult_sequencer_if.slave  bus
);

   localparam logic [3:0] ALU_NOP = 4'b0000;
   localparam logic [3:0] ALU_ADD = 4'b0011;
   localparam logic [3:0] ALU_SHL = 4'b0100;

   typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

   state_t      r_state;
   logic [31:0] r_acc;
   logic [31:0] r_mcand;
   logic [31:0] r_mplier;
   logic [5:0]  r_count;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_product;
   logic        r_alu_own;
   logic [3:0]  r_alu_op;
   logic [31:0] r_alu_a;
   logic [31:0] r_alu_b;
   logic [4:0]  r_alu_shamt;

   logic [31:0] w_mplier_shr;
   logic [5:0]  w_count_nxt;
   logic        w_finish;

   assign w_mplier_shr = r_mplier >> 1;
   assign w_count_nxt  = r_count + 6'd1;
`ifdef MULT_EARLY_EXIT_EN
   assign w_finish = (w_count_nxt == 6'(N_BITS)) || (w_mplier_shr == 32'd0);
`else
   assign w_finish = (w_count_nxt == 6'(N_BITS));
`endif

   // ALU drive values are registered one state ahead, so they are computed
   // from the values the datapath registers will hold in the state being entered.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      if (reset) begin
         r_state     <= IDLE;
         r_acc       <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_count     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_product   <= '0;
         r_alu_own   <= 1'b0;
         r_alu_op    <= ALU_NOP;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_shamt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_acc     <= '0;
                  r_mcand   <= bus.op_a;
                  r_mplier  <= bus.op_b;
                  r_count   <= '0;
                  r_product <= '0;
`ifdef MULT_EARLY_EXIT_EN
                  if (bus.op_b == 32'd0) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
`else
                  begin
`endif
                     r_state     <= ADD;
                     r_busy      <= 1'b1;
                     r_alu_own   <= 1'b1;
                     r_alu_op    <= ALU_ADD;
                     r_alu_a     <= '0;
                     r_alu_b     <= bus.op_a;
                     r_alu_shamt <= '0;
                  end
               end
            end
            ADD: begin
               if (r_mplier[0]) r_acc <= bus.alu_result;
               r_state     <= SHIFT;
               r_alu_op    <= ALU_SHL;
               r_alu_a     <= '0;
               r_alu_b     <= r_mcand;
               r_alu_shamt <= 5'd1;
            end
            SHIFT: begin
               r_mcand  <= bus.alu_result;
               r_mplier <= w_mplier_shr;
               r_count  <= w_count_nxt;
               if (w_finish) begin
                  r_state     <= DONE;
                  r_done      <= 1'b1;
                  r_product   <= r_acc;
                  r_busy      <= 1'b0;
                  r_alu_own   <= 1'b0;
                  r_alu_op    <= ALU_NOP;
                  r_alu_a     <= '0;
                  r_alu_b     <= '0;
                  r_alu_shamt <= '0;
               end else begin
                  r_state     <= ADD;
                  r_alu_op    <= ALU_ADD;
                  r_alu_a     <= r_acc;
                  r_alu_b     <= bus.alu_result;
                  r_alu_shamt <= '0;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.product   = r_product;
   assign bus.alu_own   = r_alu_own;
   assign bus.alu_op    = r_alu_op;
   assign bus.alu_a     = r_alu_a;
   assign bus.alu_b     = r_alu_b;
   assign bus.alu_shamt = r_alu_shamt;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer with a behavioural shared ALU (0011 add, 0100 shift-left B).
// Expectations for MULT_EARLY_EXIT_EN follow the same macro.
module tb_mult_sequencer;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   mult_sequencer_if bus ();

   mult_sequencer #(.N_BITS(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      bus.alu_result = 32'h0;
      case (bus.alu_op)
         4'b0011: bus.alu_result = bus.alu_a + bus.alu_b;
         4'b0100: bus.alu_result = bus.alu_b << bus.alu_shamt;
         default: bus.alu_result = 32'h0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Starts one multiply from IDLE; n counts edges since acceptance (n=0 is the cycle after E0).
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit hold,
                         output int lat, output logic [31:0] prod,
                         output int n_busy, output int n_alt_err);
      int n;
      n_busy    = 0;
      n_alt_err = 0;
      lat       = -1;
      prod      = 32'hDEAD_BEEF;
      bus.op_a  = a;
      bus.op_b  = b;
      bus.start = 1'b1;
      @(negedge clk);
      n = 0;
      if (!hold) bus.start = 1'b0;
      while (n < 200) begin
         if (bus.done) begin
            lat  = n;
            prod = bus.product;
            break;
         end
         if (bus.busy) n_busy++;
         if (bus.alu_own && bus.alu_op !== ((n % 2 == 0) ? 4'b0011 : 4'b0100)) n_alt_err++;
         if (hold && n == 10) begin
            bus.op_a = 32'h55;
            bus.op_b = 32'h3;
         end
         @(negedge clk);
         n++;
      end
      bus.start = 1'b0;
   endtask

   initial begin
      int          lat;
      int          n_busy;
      int          n_alt;
      int          exp_lat;
      logic [31:0] prod;
      bit          seen_done;

      reset     = 1'b1;
      bus.start = 1'b0;
      bus.op_a  = '0;
      bus.op_b  = '0;
      repeat (3) @(negedge clk);
      check("rst_busy",    32'(bus.busy),    32'd0);
      check("rst_done",    32'(bus.done),    32'd0);
      check("rst_alu_own", 32'(bus.alu_own), 32'd0);
      check("rst_product", bus.product,      32'd0);
      check("rst_alu_op",  32'(bus.alu_op),  32'd0);
      reset = 1'b0;
      @(negedge clk);

      // 3*5: full-length latency, busy duration
      run_op(32'd3, 32'd5, 1'b0, lat, prod, n_busy, n_alt);
      check("3x5_latency", 32'(lat),    32'd64);
      check("3x5_product", prod,        32'd15);
      check("3x5_busy",    32'(n_busy), 32'd64);
      // start presented during DONE must be dropped
      bus.op_a  = 32'd100;
      bus.op_b  = 32'd100;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("done_start_busy",  32'(bus.busy), 32'd0);
      check("done_start_done",  32'(bus.done), 32'd0);
      repeat (4) @(negedge clk);
      check("product_held",     bus.product,   32'd15);
      check("idle_alu_own",     32'(bus.alu_own), 32'd0);

      // all-ones wraps to 1; ALU op alternates ADD/SHIFT
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, prod, n_busy, n_alt);
      check("ones_product", prod,       32'h0000_0001);
      check("ones_alt",     32'(n_alt), 32'd0);
      check("ones_latency", 32'(lat),   32'd64);
      @(negedge clk);

      // ALU operand drive for 6*3 across the first ADD/SHIFT/ADD
      bus.op_a  = 32'd6;
      bus.op_b  = 32'd3;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("add0_op",    32'(bus.alu_op),    32'h3);
      check("add0_a",     bus.alu_a,          32'd0);
      check("add0_b",     bus.alu_b,          32'd6);
      check("add0_shamt", 32'(bus.alu_shamt), 32'd0);
      check("add0_own",   32'(bus.alu_own),   32'd1);
      @(negedge clk);
      check("sh0_op",     32'(bus.alu_op),    32'h4);
      check("sh0_a",      bus.alu_a,          32'd0);
      check("sh0_b",      bus.alu_b,          32'd6);
      check("sh0_shamt",  32'(bus.alu_shamt), 32'd1);
      @(negedge clk);
      check("add1_a",     bus.alu_a,          32'd6);
      check("add1_b",     bus.alu_b,          32'd12);
      seen_done = 1'b0;
      for (int i = 0; i < 100 && !seen_done; i++) begin
         @(negedge clk);
         if (bus.done) seen_done = 1'b1;
      end
      check("6x3_done_seen", 32'(seen_done), 32'd1);
      check("6x3_product",   bus.product,    32'd18);
      @(negedge clk);

      // start held high with operands changing mid-run
      run_op(32'd9, 32'd11, 1'b1, lat, prod, n_busy, n_alt);
      check("hold_product", prod,     32'd99);
      check("hold_latency", 32'(lat), 32'd64);
      @(negedge clk);
      check("hold_single_done", 32'(bus.done), 32'd0);
      check("hold_no_restart",  32'(bus.busy), 32'd0);

      // overflow beyond 32 bits is discarded
      run_op(32'h0001_0000, 32'h0001_0003, 1'b0, lat, prod, n_busy, n_alt);
      check("ovf_product", prod, 32'h0003_0000);
      @(negedge clk);

      // reset at E20 of a 7*6 operation
      bus.op_a  = 32'd7;
      bus.op_b  = 32'd6;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (19) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mrst_busy",    32'(bus.busy),    32'd0);
      check("mrst_done",    32'(bus.done),    32'd0);
      check("mrst_alu_own", 32'(bus.alu_own), 32'd0);
      check("mrst_alu_op",  32'(bus.alu_op),  32'd0);
      check("mrst_alu_a",   bus.alu_a,        32'd0);
      check("mrst_alu_b",   bus.alu_b,        32'd0);
      check("mrst_product", bus.product,      32'd0);
      reset     = 1'b0;
      seen_done = 1'b0;
      repeat (80) begin
         @(negedge clk);
         if (bus.done || bus.busy) seen_done = 1'b1;
      end
      check("mrst_no_done", 32'(seen_done), 32'd0);
      run_op(32'd7, 32'd6, 1'b0, lat, prod, n_busy, n_alt);
      check("after_rst_product", prod, 32'd42);
      @(negedge clk);

      // early-exit cases; full latency when the feature is compiled out
`ifdef MULT_EARLY_EXIT_EN
      exp_lat = 6;
`else
      exp_lat = 64;
`endif
      run_op(32'd7, 32'd4, 1'b0, lat, prod, n_busy, n_alt);
      check("7x4_product", prod,     32'd28);
      check("7x4_latency", 32'(lat), 32'(exp_lat));
      @(negedge clk);
`ifdef MULT_EARLY_EXIT_EN
      exp_lat = 0;
`else
      exp_lat = 64;
`endif
      run_op(32'd123, 32'd0, 1'b0, lat, prod, n_busy, n_alt);
      check("bzero_product", prod,     32'd0);
      check("bzero_latency", 32'(lat), 32'(exp_lat));
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
